// File: rtl/cache_control_l1.sv
// ----------------------------------------------------------------------------
// cache_control_l1
//
// Control FSM for a 2-way set-associative L1 cache. Accepts CPU requests,
// detects hits from the ways' hit/dirty status, chooses an LRU victim on a
// miss, and runs the writeback/fill handshake with the next memory level.
// The datapath (address/data muxes and the ways) is outside this block and
// is steered by way_sel and pmem_addr_sel.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   set                         set index of the current CPU address
//   mem_read, mem_write         CPU request, held until mem_resp
//   mem_resp                    one-cycle completion pulse to the CPU
//   hit0/1, dirty0/1            combinational status from way 0/1 for set
//   load_word0/1                word write strobe to way 0/1 (CPU store)
//   load_line0/1                line fill strobe to way 0/1
//   way_sel                     way select for data out and writeback tag
//   pmem_addr_sel               0 = CPU address (fill), 1 = writeback address
//   pmem_read, pmem_write       lower-level request, held until pmem_resp
//   pmem_resp                   lower-level completion pulse
//   hit_count, miss_count       performance counters
//   state_dbg                   current FSM state (CHECK=0, WRITEBACK=1,
//                               FILL=2) for observation
//
// Handshakes: the CPU holds mem_read/mem_write until mem_resp is seen high
// for one cycle; this block holds pmem_read/pmem_write until pmem_resp is
// seen high for one cycle. pmem_resp outside WRITEBACK/FILL is ignored.
//
// Build option: define CACHE_L1_PERF_CNT_EN to include the saturating
// hit/miss counters; otherwise both counter ports are tied to 0.
// ----------------------------------------------------------------------------
module cache_control_l1 #(
    parameter int sets = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [$clog2(sets)-1:0]  set,
    input  logic                     mem_read,
    input  logic                     mem_write,
    output logic                     mem_resp,
    input  logic                     hit0,
    input  logic                     hit1,
    input  logic                     dirty0,
    input  logic                     dirty1,
    output logic                     load_word0,
    output logic                     load_word1,
    output logic                     load_line0,
    output logic                     load_line1,
    output logic                     way_sel,
    output logic                     pmem_addr_sel,
    output logic                     pmem_read,
    output logic                     pmem_write,
    input  logic                     pmem_resp,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count,
    output logic [1:0]               state_dbg
);

    typedef enum logic [1:0] {
        CHECK     = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    state_t            state;
    logic [sets-1:0]   lru;      // lru[s] = way to evict next in set s
    logic              victim;   // victim way, frozen for the whole miss

    logic req;
    logic hit;
    logic hit_way;
    logic lru_way;
    logic victim_dirty;

    assign req          = mem_read | mem_write;
    assign hit          = hit0 | hit1;
    // Way 0 wins if both ways report a hit.
    assign hit_way      = ~hit0;
    assign lru_way      = lru[set];
    assign victim_dirty = lru_way ? dirty1 : dirty0;

    assign state_dbg = state;

    // ------------------------------------------------------------------
    // State, LRU and victim registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= CHECK;
            lru    <= '0;
            victim <= 1'b0;
        end else begin
            case (state)
                CHECK: begin
                    if (req && hit) begin
                        lru[set] <= ~hit_way;
                    end else if (req) begin
                        victim <= lru_way;
                        state  <= victim_dirty ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) state <= FILL;
                end
                FILL: begin
                    if (pmem_resp) state <= CHECK;
                end
                default: state <= CHECK;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode. Hit response and line load are same-cycle reactions
    // to hit/pmem_resp, so outputs are decoded from state plus inputs.
    // Everything is forced low while reset is asserted so that an
    // in-flight pmem request drops immediately.
    // ------------------------------------------------------------------
    always_comb begin
        mem_resp      = 1'b0;
        load_word0    = 1'b0;
        load_word1    = 1'b0;
        load_line0    = 1'b0;
        load_line1    = 1'b0;
        way_sel       = 1'b0;
        pmem_addr_sel = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        if (rst_n) begin
            case (state)
                CHECK: begin
                    if (req && hit) begin
                        mem_resp   = 1'b1;
                        way_sel    = hit_way;
                        // A simultaneous read+write is handled as a write.
                        load_word0 = mem_write & ~hit_way;
                        load_word1 = mem_write &  hit_way;
                    end
                end
                WRITEBACK: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                    way_sel       = victim;
                end
                FILL: begin
                    pmem_read  = 1'b1;
                    way_sel    = victim;
                    load_line0 = pmem_resp & ~victim;
                    load_line1 = pmem_resp &  victim;
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_L1_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating performance counters. Retry hits after a fill count as
    // hits because they produce a CHECK-state mem_resp.
    // ------------------------------------------------------------------
    logic hit_evt;
    logic miss_evt;

    assign hit_evt  = (state == CHECK) && req && hit;
    assign miss_evt = (state == CHECK) && req && !hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_evt && (hit_count != 32'hFFFF_FFFF))
                hit_count <= hit_count + 32'd1;
            if (miss_evt && (miss_count != 32'hFFFF_FFFF))
                miss_count <= miss_count + 32'd1;
        end
    end
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_cache_control_l1.sv
// ----------------------------------------------------------------------------
// tb_cache_control_l1
//
// Directed bench for cache_control_l1. Drivers push the expected strobe
// response (mem_resp / load_word / load_line with way_sel) into exp_q when
// they issue stimulus; a monitor pops and compares whenever the DUT raises
// any of those strobes. Drivers additionally check the pmem handshake
// cycle by cycle, and a protocol monitor checks exclusivity rules.
// ----------------------------------------------------------------------------
module tb_cache_control_l1;

    localparam int SETS = 8;

    logic        clk;
    logic        rst_n;
    logic [2:0]  set;
    logic        mem_read, mem_write, mem_resp;
    logic        hit0, hit1, dirty0, dirty1;
    logic        load_word0, load_word1, load_line0, load_line1;
    logic        way_sel, pmem_addr_sel, pmem_read, pmem_write, pmem_resp;
    logic [31:0] hit_count, miss_count;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    // {mem_resp, way_sel, load_word0, load_word1, load_line0, load_line1}
    logic [5:0] exp_q[$];

    logic lru_m[SETS];
    int   hits_m;
    int   misses_m;

    cache_control_l1 #(.sets(SETS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .set           (set),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_resp      (mem_resp),
        .hit0          (hit0),
        .hit1          (hit1),
        .dirty0        (dirty0),
        .dirty1        (dirty1),
        .load_word0    (load_word0),
        .load_word1    (load_word1),
        .load_line0    (load_line0),
        .load_line1    (load_line1),
        .way_sel       (way_sel),
        .pmem_addr_sel (pmem_addr_sel),
        .pmem_read     (pmem_read),
        .pmem_write    (pmem_write),
        .pmem_resp     (pmem_resp),
        .hit_count     (hit_count),
        .miss_count    (miss_count),
        .state_dbg     (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < SETS; i++) lru_m[i] = 1'b0;
        hits_m   = 0;
        misses_m = 0;
    endtask

    task automatic idle_inputs();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        hit0      = 1'b0;
        hit1      = 1'b0;
        dirty0    = 1'b0;
        dirty1    = 1'b0;
        pmem_resp = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && (mem_resp | load_word0 | load_word1 | load_line0 | load_line1)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe",
                      {26'd0, mem_resp, way_sel, load_word0, load_word1, load_line0, load_line1},
                      32'd0);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                check("strobe_vec",
                      {26'd0, mem_resp, way_sel, load_word0, load_word1, load_line0, load_line1},
                      {26'd0, e});
            end
        end
    end

    // ---------------- protocol monitor ----------------
    always @(negedge clk) begin
        if (pmem_read && pmem_write)
            check("pmem_rd_wr_excl", 32'd1, 32'd0);
        if ((state_dbg == 2'd0) && (pmem_read || pmem_write))
            check("pmem_in_check", 32'd1, 32'd0);
        if ((load_word0 + load_word1 + load_line0 + load_line1) > 1)
            check("load_one_hot", 32'd1, 32'd0);
    end

    // ---------------- drivers ----------------
    // One-cycle hit request; expects 0-wait mem_resp.
    task automatic do_hit(input logic rd, input logic wr, input logic [2:0] s,
                          input logic h0, input logic h1);
        logic w;
        w = h0 ? 1'b0 : 1'b1;
        mem_read  = rd;
        mem_write = wr;
        set       = s;
        hit0      = h0;
        hit1      = h1;
        exp_q.push_back({1'b1, w, wr & ~w, wr & w, 1'b0, 1'b0});
        lru_m[s] = ~w;
        hits_m++;
        next_cycle();
        idle_inputs();
    endtask

    // Miss on set s; victim comes from the bench's LRU model. w_cyc/f_cyc
    // are the cycle counts spent in WRITEBACK/FILL (pmem_resp on the last).
    task automatic do_miss(input logic wr, input logic [2:0] s, input logic dirty_v,
                           input int w_cyc, input int f_cyc, input logic drop);
        logic v;
        v = lru_m[s];
        mem_read  = ~wr;
        mem_write = wr;
        set       = s;
        hit0      = 1'b0;
        hit1      = 1'b0;
        dirty0    = dirty_v & ~v;
        dirty1    = dirty_v &  v;
        @(negedge clk);
        check("miss_no_resp", {31'd0, mem_resp}, 32'd0);
        check("miss_check_state", {30'd0, state_dbg}, 32'd0);
        next_cycle();
        misses_m++;
        if (drop) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
        if (dirty_v) begin
            for (int i = 0; i < w_cyc; i++) begin
                pmem_resp = (i == w_cyc - 1);
                @(negedge clk);
                check("wb_wr_rd_asel_way", {28'd0, pmem_write, pmem_read, pmem_addr_sel, way_sel},
                      {28'd0, 1'b1, 1'b0, 1'b1, v});
                next_cycle();
            end
        end
        for (int i = 0; i < f_cyc; i++) begin
            pmem_resp = (i == f_cyc - 1);
            if (i == f_cyc - 1)
                exp_q.push_back({1'b0, v, 1'b0, 1'b0, ~v, v});
            @(negedge clk);
            check("fill_wr_rd_asel_way", {28'd0, pmem_write, pmem_read, pmem_addr_sel, way_sel},
                  {28'd0, 1'b0, 1'b1, 1'b0, v});
            check("fill_no_resp", {31'd0, mem_resp}, 32'd0);
            next_cycle();
        end
        pmem_resp = 1'b0;
        dirty0    = 1'b0;
        dirty1    = 1'b0;
        if (!drop) begin
            // Retry: the filled way now hits.
            hit0 = ~v;
            hit1 = v;
            exp_q.push_back({1'b1, v, wr & ~v, wr & v, 1'b0, 1'b0});
            lru_m[s] = ~v;
            hits_m++;
        end
        @(negedge clk);
        check("back_in_check", {30'd0, state_dbg}, 32'd0);
        next_cycle();
        idle_inputs();
    endtask

    task automatic check_counters(input string name);
`ifdef CACHE_L1_PERF_CNT_EN
        check({name, "_hits"},   hit_count,  hits_m);
        check({name, "_misses"}, miss_count, misses_m);
`else
        check({name, "_hits"},   hit_count,  32'd0);
        check({name, "_misses"}, miss_count, 32'd0);
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        set   = 3'd0;
        idle_inputs();
        clear_model();
        // Request with a hit while in reset: every output must stay low.
        mem_read = 1'b1;
        hit0     = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              {23'd0, mem_resp, load_word0, load_word1, load_line0, load_line1,
               way_sel, pmem_addr_sel, pmem_read, pmem_write},
              32'd0);
        check("reset_state", {30'd0, state_dbg}, 32'd0);
        check_counters("reset");
        idle_inputs();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // Read hit on way 1, set 3 -> lru[3]=0, next miss on set 3 picks way 0.
        do_hit(1'b1, 1'b0, 3'd3, 1'b0, 1'b1);
        do_miss(1'b0, 3'd3, 1'b0, 0, 2, 1'b0);

        // Write hit on way 0, set 5 -> load_word0, lru[5]=1.
        do_hit(1'b0, 1'b1, 3'd5, 1'b1, 1'b0);
        do_miss(1'b0, 3'd5, 1'b0, 0, 1, 1'b0);

        // Clean miss on set 2, pmem_resp after 4 FILL cycles.
        do_miss(1'b0, 3'd2, 1'b0, 0, 4, 1'b0);

        // Make way 1 the victim of set 7, then a dirty write miss.
        do_hit(1'b1, 1'b0, 3'd7, 1'b1, 1'b0);
        do_miss(1'b1, 3'd7, 1'b1, 3, 2, 1'b0);

        // Read and write together on a way-1 hit behave as a write.
        do_hit(1'b1, 1'b1, 3'd1, 1'b0, 1'b1);

        // Request dropped during a dirty miss: handshake completes, no resp.
        do_miss(1'b0, 3'd0, 1'b1, 2, 2, 1'b1);

        // Stray pmem_resp in CHECK is ignored.
        pmem_resp = 1'b1;
        next_cycle();
        pmem_resp = 1'b0;
        @(negedge clk);
        check("stray_pmem_resp_state", {30'd0, state_dbg}, 32'd0);
        next_cycle();

        check_counters("mid");

        // Reset during FILL drops pmem_read immediately.
        do_hit(1'b1, 1'b0, 3'd6, 1'b1, 1'b0);   // lru[6]=1
        mem_read = 1'b1;
        set      = 3'd6;
        next_cycle();                            // now in FILL for way 1
        @(negedge clk);
        check("fill_before_reset", {31'd0, pmem_read}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_drops_pmem_read", {30'd0, pmem_read, pmem_write}, 32'd0);
        check("reset_state_async", {30'd0, state_dbg}, 32'd0);
        idle_inputs();
        clear_model();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        check("post_reset_state", {30'd0, state_dbg}, 32'd0);
        check_counters("post_reset");

        // Set 6 victim is way 0 again after reset; then 3 hits.
        do_miss(1'b0, 3'd6, 1'b0, 0, 2, 1'b0);
        do_hit(1'b1, 1'b0, 3'd4, 1'b1, 1'b0);
        do_hit(1'b0, 1'b1, 3'd2, 1'b0, 1'b1);
        do_hit(1'b1, 1'b0, 3'd6, 1'b1, 1'b0);
        next_cycle();
`ifdef CACHE_L1_PERF_CNT_EN
        check("perf_hit_count", hit_count, 32'd4);
        check("perf_miss_count", miss_count, 32'd1);
`else
        check("perf_hit_count", hit_count, 32'd0);
        check("perf_miss_count", miss_count, 32'd0);
`endif

        repeat (3) next_cycle();
        check("exp_q_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
